ram1_bus_arbiter: RTL and testbench

Sequences and shares the RAM1/UART bus port between two requesters: the instruction-fetch port (read-only) and the data-memory port (read/write). It sits between the pipeline's IF/MEM stages and the RAM1/UART bus block. It decodes UART addresses, holds bus controls stable for a fixed multi-cycle access window and returns read data with a one-cycle acknowledge. Pending requesters stall until acknowledged.

---
 rtl/ram1_bus_arbiter_if.sv | 38 +++
 rtl/ram1_bus_arbiter.sv | 108 ++++++++++
 tb/tb_ram1_bus_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ram1_bus_arbiter_if.sv
// rtl/ram1_bus_arbiter_if.sv - requester ports and RAM1/UART bus signals of the arbiter
interface ram1_bus_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              i_stall;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_stall;
  logic              is_RAM1_o;
  logic              is_UART_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] data_o;
  logic              isread_o;
  logic              iswrite_o;
  logic [DATA_W-1:0] ram1res_i;
  logic              busy_o;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram1res_i,
    output i_rdata, i_ack, i_stall, d_rdata, d_ack, d_stall,
    output is_RAM1_o, is_UART_o, addr_o, data_o, isread_o, iswrite_o, busy_o
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram1res_i,
    input  i_rdata, i_ack, i_stall, d_rdata, d_ack, d_stall,
    input  is_RAM1_o, is_UART_o, addr_o, data_o, isread_o, iswrite_o, busy_o
  );
endinterface

// File: rtl/ram1_bus_arbiter.sv
// rtl/ram1_bus_arbiter.sv - shares the RAM1/UART bus between fetch and data ports
module ram1_bus_arbiter #(
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 16,
  parameter int ACCESS_CYCLES  = 2,
  parameter int MAX_DATA_BURST = 4
) (
  input logic               clk,
  input logic               rst,
  ram1_bus_arbiter_if.slave bus
);
  localparam int CNT_W   = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int BURST_W = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic               grant_d;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               starved, take_data, take_fetch;
  logic               in_access, in_ack, is_uart, is_status;

  // Fetch only overrides data once the data port has used its burst allowance.
  assign starved = (burst_cnt == BURST_MAX) && bus.i_req;

  always_comb begin
    state_next = state;
    take_data  = 1'b0;
    take_fetch = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_req && !starved) begin
          take_data  = 1'b1;
          state_next = ACCESS;
        end else if (bus.i_req) begin
          take_fetch = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS:  if (cnt == CNT_LAST) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      burst_cnt <= '0;
      grant_d   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      if (take_data) begin
        grant_d   <= 1'b1;
        we_q      <= bus.d_we;
        addr_q    <= bus.d_addr;
        wdata_q   <= bus.d_wdata;
        burst_cnt <= bus.i_req ? burst_cnt + 1'b1 : '0;
      end else if (take_fetch) begin
        grant_d   <= 1'b0;
        we_q      <= 1'b0;
        addr_q    <= bus.i_addr;
        burst_cnt <= '0;
      end
      if (state == ACCESS) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        // Read data is valid only on the edge that closes the access window.
        if (cnt == CNT_LAST && !we_q) rdata_q <= bus.ram1res_i;
      end
    end
  end

  assign in_access = (state == ACCESS);
  assign in_ack    = (state == ACK);
  assign is_uart   = (addr_q[15:0] == 16'hBF00) || (addr_q[15:0] == 16'hBF01);
  assign is_status = (addr_q[15:0] == 16'hBF01);

  assign bus.is_RAM1_o = in_access && !is_uart;
  assign bus.is_UART_o = in_access && is_uart;
  assign bus.isread_o  = in_access && !we_q;
  // The UART status register is read-only; writes run the window without a strobe.
  assign bus.iswrite_o = in_access && we_q && !is_status;
  assign bus.addr_o    = addr_q;
  assign bus.data_o    = wdata_q;
  assign bus.busy_o    = (state != IDLE);

  assign bus.i_ack   = in_ack && !grant_d;
  assign bus.d_ack   = in_ack && grant_d;
  assign bus.i_stall = bus.i_req && !bus.i_ack;
  assign bus.d_stall = bus.d_req && !bus.d_ack;
  assign bus.i_rdata = rdata_q;
  assign bus.d_rdata = rdata_q;
endmodule

// File: tb/tb_ram1_bus_arbiter.sv
// tb/tb_ram1_bus_arbiter.sv - directed vector bench for ram1_bus_arbiter
module tb_ram1_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ram1_bus_arbiter_if #(.ADDR_W(18), .DATA_W(16)) bus ();

  ram1_bus_arbiter #(
    .ADDR_W(18), .DATA_W(16), .ACCESS_CYCLES(2), .MAX_DATA_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        fetch;
    logic        we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] rres;
    logic [3:0]  sel;    // {is_RAM1_o, is_UART_o, isread_o, iswrite_o}
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] sel_now();
    return {bus.is_RAM1_o, bus.is_UART_o, bus.isread_o, bus.iswrite_o};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    if (v.fetch) begin
      bus.i_req  = 1'b1;
      bus.i_addr = v.addr;
    end else begin
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
    end
    bus.ram1res_i = ~v.rres;
    step();
    for (int c = 0; c < 2; c++) begin
      chk({t, "_sel"}, 32'(sel_now()), 32'(v.sel));
      chk({t, "_addr"}, 32'(bus.addr_o), 32'(v.addr));
      chk({t, "_busy"}, 32'(bus.busy_o), 32'd1);
      chk({t, "_ack_early"}, 32'({bus.i_ack, bus.d_ack}), 32'd0);
      chk({t, "_stall"}, 32'(bus.i_stall | bus.d_stall), 32'd1);
      if (!v.fetch) chk({t, "_data_o"}, 32'(bus.data_o), 32'(v.wdata));
      if (c == 1) bus.ram1res_i = v.rres;
      step();
    end
    chk({t, "_ack"}, 32'({bus.i_ack, bus.d_ack}), v.fetch ? 32'd2 : 32'd1);
    chk({t, "_rdata"}, 32'(v.fetch ? bus.i_rdata : bus.d_rdata), 32'(v.rdata));
    chk({t, "_sel_ack"}, 32'(sel_now()), 32'd0);
    chk({t, "_stall_ack"}, 32'(bus.i_stall | bus.d_stall), 32'd0);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step();
    chk({t, "_ack_after"}, 32'({bus.i_ack, bus.d_ack}), 32'd0);
    chk({t, "_idle"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n_acks;
    logic        order[6];
    logic [5:0]  exp_order;
    int          cnt_i, cnt_d;
    logic        first_d, seen;

    vecs[0] = '{1'b1, 1'b0, 18'h00010, 16'h0000, 16'hA5A5, 4'b1010, 16'hA5A5};
    vecs[1] = '{1'b0, 1'b1, 18'h0BF00, 16'h0041, 16'h0000, 4'b0101, 16'hA5A5};
    vecs[2] = '{1'b0, 1'b1, 18'h0BF01, 16'h0055, 16'h0000, 4'b0100, 16'hA5A5};
    vecs[3] = '{1'b0, 1'b0, 18'h00020, 16'h0000, 16'h5A5A, 4'b1010, 16'h5A5A};
    vecs[4] = '{1'b0, 1'b1, 18'h12345, 16'hBEEF, 16'h0000, 4'b1001, 16'h5A5A};
    vecs[5] = '{1'b0, 1'b0, 18'h3BF00, 16'h0000, 16'h0077, 4'b0110, 16'h0077};
    vecs[6] = '{1'b1, 1'b0, 18'h0BF01, 16'h0000, 16'h0003, 4'b0110, 16'h0003};

    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.ram1res_i = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_sel", 32'(sel_now()), 32'd0);
    chk("rst_ack", 32'({bus.i_ack, bus.d_ack}), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_addr", 32'(bus.addr_o), 32'd0);
    chk("rst_data", 32'(bus.data_o), 32'd0);
    chk("rst_rdata", 32'(bus.i_rdata), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Starvation: both ports held; fetch must win after four data grants.
    bus.i_req = 1'b1; bus.i_addr = 18'h00100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 18'h00200;
    n_acks = 0;
    for (int c = 0; c < 60 && n_acks < 6; c++) begin
      step();
      if (bus.i_ack && bus.d_ack) chk("starve_both_ack", 32'd1, 32'd0);
      if (bus.i_ack || bus.d_ack) begin
        order[n_acks] = bus.d_ack;
        n_acks++;
      end
    end
    chk("starve_count", 32'(n_acks), 32'd6);
    exp_order = 6'b111101;
    for (int k = 0; k < 6 && k < n_acks; k++)
      chk($sformatf("starve_order%0d", k), 32'(order[k]), 32'(exp_order[5-k]));
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step();
    step();
    chk("starve_idle", 32'(bus.busy_o), 32'd0);

    // Reset during the second access cycle abandons the access.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 18'h00040;
    bus.ram1res_i = 16'h0BAD;
    step();
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    chk("mid_rst_ack", 32'(bus.d_ack), 32'd0);
    chk("mid_rst_sel", 32'(sel_now()), 32'd0);
    rst = 1'b0;
    step();
    chk("restart_sel", 32'(sel_now()), 32'b1010);
    chk("restart_busy", 32'(bus.busy_o), 32'd1);
    bus.ram1res_i = 16'h0C0D;
    step();
    step();
    chk("restart_ack", 32'(bus.d_ack), 32'd1);
    chk("restart_rdata", 32'(bus.d_rdata), 32'h0C0D);
    bus.d_req = 1'b0;
    step();

    // Simultaneous reads; bus model answers by address.
    bus.i_req = 1'b1; bus.i_addr = 18'h00000;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 18'h0BF01;
    cnt_i = 0; cnt_d = 0; first_d = 1'b0; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      bus.ram1res_i = (bus.addr_o == 18'h00000) ? 16'h1234 : 16'h0003;
      if (bus.d_ack) begin
        cnt_d++;
        if (!seen) first_d = 1'b1;
        seen = 1'b1;
        chk("b2b_d_rdata", 32'(bus.d_rdata), 32'h0003);
        bus.d_req = 1'b0;
      end
      if (bus.i_ack) begin
        cnt_i++;
        seen = 1'b1;
        chk("b2b_i_rdata", 32'(bus.i_rdata), 32'h1234);
        bus.i_req = 1'b0;
      end
    end
    chk("b2b_first_data", 32'(first_d), 32'd1);
    chk("b2b_d_count", 32'(cnt_d), 32'd1);
    chk("b2b_i_count", 32'(cnt_i), 32'd1);
    chk("b2b_idle", 32'(bus.busy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
